// File: rtl/uart_rx_if.sv
// Receive-side signal bundle for uart_rx: serial line in, byte/status out.
// The slave modport is the receiver; the master modport is the line driver / byte consumer.
interface uart_rx_if;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_busy;

  modport master (
    output i_rx,
    input  o_data,
    input  o_valid,
    input  o_frame_err,
    input  o_busy
  );

  modport slave (
    input  i_rx,
    output o_data,
    output o_valid,
    output o_frame_err,
    output o_busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes the serial line, samples mid-bit using a baud counter,
// and reports each frame as a one-cycle o_valid (good stop bit) or o_frame_err (stop bit low).
module uart_rx #(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic     i_clk,
  input  logic     i_reset_n,
  uart_rx_if.slave bus
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic             rx_p0;
  logic             rx_s;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       bit_idx, bit_idx_nx;
  logic [7:0]       shift, shift_nx;
  logic [7:0]       data, data_nx;
  logic             valid, valid_nx;
  logic             frame_err, frame_err_nx;

  // Stage p0/p1: two-flop synchronizer, idle-high so reset never looks like a start bit
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rx_p0 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_p0 <= bus.i_rx;
      rx_s  <= rx_p0;
    end
  end

  // Frame state, baud counter, shifter and output registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      bit_idx   <= bit_idx_nx;
      shift     <= shift_nx;
      data      <= data_nx;
      valid     <= valid_nx;
      frame_err <= frame_err_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt + 1'b1;
    bit_idx_nx   = bit_idx;
    shift_nx     = shift;
    data_nx      = data;
    valid_nx     = 1'b0;
    frame_err_nx = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (!rx_s) state_nx = S_START;
      end

      S_START: begin
        if (cnt == CNT_HALF) begin
          if (!rx_s) begin
            state_nx   = S_DATA;
            bit_idx_nx = '0;
          end else begin
            state_nx = S_IDLE;
          end
        end
      end

      S_DATA: begin
        if (cnt == CNT_LAST) begin
          // LSB arrives first, so each new bit enters at the MSB and moves down
          shift_nx = {rx_s, shift[7:1]};
          cnt_nx   = '0;
          if (bit_idx == 3'd7) state_nx = S_STOP;
          else                 bit_idx_nx = bit_idx + 1'b1;
        end
      end

      S_STOP: begin
        if (cnt == CNT_LAST) begin
          if (rx_s) begin
            data_nx  = shift;
            valid_nx = 1'b1;
            state_nx = S_IDLE;
          end else begin
            frame_err_nx = 1'b1;
            state_nx     = S_BREAK;
          end
        end
      end

      S_BREAK: begin
        if (rx_s) state_nx = S_IDLE;
      end

      default: state_nx = S_IDLE;
    endcase

    // Every state entry restarts bit timing from zero
    if (state_nx != state) cnt_nx = '0;
  end

  assign bus.o_data      = data;
  assign bus.o_valid     = valid;
  assign bus.o_frame_err = frame_err;
  assign bus.o_busy      = (state != S_IDLE);

endmodule
